// File: rtl/camera_rgb332_capture_if.sv
// Signal bundle between the OV7670 byte stream, the capture stage and the frame buffer.
// W_EN is a valid-only strobe: the frame buffer always accepts, so there is no ready and a write is taken on any cycle where W_EN=1.
interface camera_rgb332_capture_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        PIXEL_DATA;
    logic              HREF;
    logic              VSYNC;
    logic [7:0]        PIXEL_OUT;
    logic [ADDR_W-1:0] WRITE_ADDR;
    logic              W_EN;
    logic [7:0]        X_ADDR;
    logic [7:0]        Y_ADDR;
    logic              FRAME_DONE;
    logic [1:0]        state_dbg;

    modport master (
        output PIXEL_DATA, HREF, VSYNC,
        input  PIXEL_OUT, WRITE_ADDR, W_EN, X_ADDR, Y_ADDR, FRAME_DONE, state_dbg
    );

    modport slave (
        input  PIXEL_DATA, HREF, VSYNC,
        output PIXEL_OUT, WRITE_ADDR, W_EN, X_ADDR, Y_ADDR, FRAME_DONE, state_dbg
    );
endinterface

// File: rtl/camera_rgb332_capture.sv
// OV7670 RGB565 byte-stream capture: packs each pixel to RGB332 and writes it,
// clipped to the window, into the frame buffer at Y*SCREEN_WIDTH+X.
module camera_rgb332_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input logic CLK,
    input logic RESET,
    camera_rgb332_capture_if.slave cam
);
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LINE_IDLE  = 2'd1,
        BYTE_HI    = 2'd2,
        BYTE_LO    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [2:0]        r_q, r_d;
    logic [2:0]        g_q, g_d;
    logic [7:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              href_q, vsync_q;

    logic              vsync_fall, vsync_rise, href_fall, in_window;
    logic [ADDR_W-1:0] pix_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign vsync_fall = vsync_q & ~cam.VSYNC;
    assign vsync_rise = ~vsync_q & cam.VSYNC;
    assign href_fall  = href_q & ~cam.HREF;
    assign in_window  = (32'(x_q) < SCREEN_WIDTH) && (32'(y_q) < SCREEN_HEIGHT);
    assign pix_addr   = ADDR_W'(y_q) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= WAIT_FRAME;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            href_q  <= cam.HREF;
            vsync_q <= cam.VSYNC;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            href_q  <= cam.HREF;
            vsync_q <= cam.VSYNC;
        end
    end

    // LINE_IDLE and BYTE_HI both treat a byte seen with HREF=1 as the high byte,
    // so the first byte of a line is never lost to the state transition.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        g_d     = g_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        if (state_q == WAIT_FRAME) begin
            if (vsync_fall) begin
                x_d = '0;
                y_d = '0;
                if (cam.HREF) begin
                    r_d     = cam.PIXEL_DATA[7:5];
                    g_d     = cam.PIXEL_DATA[2:0];
                    state_d = BYTE_LO;
                end else begin
                    state_d = LINE_IDLE;
                end
            end
        end else if (vsync_rise) begin
            state_d = WAIT_FRAME;
            done_d  = 1'b1;
        end else if (cam.HREF) begin
            if (state_q == BYTE_LO) begin
                pix_d   = {r_q, g_q, cam.PIXEL_DATA[4:3]};
                wen_d   = in_window;
                addr_d  = in_window ? pix_addr : addr_q;
                pix_d   = in_window ? pix_d : pix_q;
                x_d     = sat_inc(x_q);
                state_d = BYTE_HI;
            end else begin
                r_d     = cam.PIXEL_DATA[7:5];
                g_d     = cam.PIXEL_DATA[2:0];
                state_d = BYTE_LO;
            end
        end else if (href_fall) begin
            x_d     = '0;
            y_d     = sat_inc(y_q);
            state_d = LINE_IDLE;
        end
    end

    assign cam.PIXEL_OUT  = pix_q;
    assign cam.WRITE_ADDR = addr_q;
    assign cam.W_EN       = wen_q;
    assign cam.X_ADDR     = x_q;
    assign cam.Y_ADDR     = y_q;
    assign cam.FRAME_DONE = done_q;
    assign cam.state_dbg  = state_q;
endmodule

// File: tb/tb_camera_rgb332_capture.sv
// Directed bench for camera_rgb332_capture: byte-level camera stimulus with a
// write scoreboard of hand-computed {address, pixel} pairs.
module tb_camera_rgb332_capture;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   wen_cnt;
    int   base;
    logic prev_wen;
    logic [22:0] exp_q[$];

    camera_rgb332_capture_if #(.ADDR_W(15)) cam ();

    camera_rgb332_capture #(
        .SCREEN_WIDTH(176),
        .SCREEN_HEIGHT(144),
        .ADDR_W(15)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .cam(cam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Applies one byte slot; returns 1 time unit after the edge that sampled it.
    task automatic drive(input logic [7:0] d, input logic h, input logic v);
        cam.PIXEL_DATA = d;
        cam.HREF       = h;
        cam.VSYNC      = v;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [7:0] pix);
        exp_q.push_back({15'(addr), pix});
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {cam.PIXEL_OUT, cam.WRITE_ADDR, cam.W_EN, cam.X_ADDR, cam.Y_ADDR, cam.FRAME_DONE}, 0);
    endtask

    initial begin
        logic [22:0] e;
        prev_wen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cam.W_EN) begin
                wen_cnt++;
                check("wen_gap", 32'(prev_wen), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wen", 32'(cam.W_EN), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {9'd0, cam.WRITE_ADDR, cam.PIXEL_OUT}, {9'd0, e});
                end
            end
            prev_wen = cam.W_EN;
        end
    end

    initial begin
        total = 0; bad = 0; wen_cnt = 0;
        rst = 1'b1;
        cam.PIXEL_DATA = 8'h00; cam.HREF = 1'b0; cam.VSYNC = 1'b1;
        @(posedge clk);
        #1;

        // reset held with HREF/VSYNC toggling
        drive(8'hAA, 1'b1, 1'b0); check_reset_outputs("reset_c1");
        drive(8'h55, 1'b0, 1'b1); check_reset_outputs("reset_c2");
        drive(8'hF0, 1'b1, 1'b1); check_reset_outputs("reset_c3");
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b1); check_reset_outputs("after_reset");

        // frame start coincident with first HREF byte
        drive(8'hF8, 1'b1, 1'b0);
        push(0, 8'hE0);
        drive(8'h00, 1'b1, 1'b0);
        check("latency_wen", 32'(cam.W_EN), 1);
        drive(8'h07, 1'b1, 1'b0);
        push(1, 8'h1C);
        drive(8'hE0, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        push(2, 8'h03);
        drive(8'h1F, 1'b1, 1'b0);
        check("x_after_3px", 32'(cam.X_ADDR), 3);
        drive(8'h00, 1'b0, 1'b0);
        check("x_line_end", 32'(cam.X_ADDR), 0);
        check("y_line_end", 32'(cam.Y_ADDR), 1);
        drive(8'h00, 1'b0, 1'b0);

        // second line
        drive(8'hFF, 1'b1, 1'b0);
        push(176, 8'hFF);
        drive(8'hFF, 1'b1, 1'b0);
        check("y_line2", 32'(cam.Y_ADDR), 1);
        drive(8'h00, 1'b0, 1'b0);

        // odd-length line: the trailing byte is dropped
        drive(8'h12, 1'b1, 1'b0);
        push(352, 8'h0A);
        drive(8'h34, 1'b1, 1'b0);
        drive(8'h56, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check("y_after_odd", 32'(cam.Y_ADDR), 3);
        drive(8'hE5, 1'b1, 1'b0);
        push(528, 8'hF7);
        drive(8'h18, 1'b1, 1'b0);
        check("x_after_odd", 32'(cam.X_ADDR), 1);
        drive(8'h00, 1'b0, 1'b0);

        // 180-pixel line at Y=4: only X<176 is written
        base = wen_cnt;
        for (int i = 0; i < 180; i++) begin
            if (i < 176) push(704 + i, 8'hB7);
            drive(8'hA5, 1'b1, 1'b0);
            drive(8'h18, 1'b1, 1'b0);
        end
        check("x_after_180", 32'(cam.X_ADDR), 180);
        drive(8'h00, 1'b0, 1'b0);
        check("writes_180_line", 32'(wen_cnt - base), 176);

        // advance to Y=144 with one-byte lines
        for (int i = 0; i < 139; i++) begin
            drive(8'hFF, 1'b1, 1'b0);
            drive(8'h00, 1'b0, 1'b0);
        end
        check("y_at_144", 32'(cam.Y_ADDR), 144);
        base = wen_cnt;
        for (int i = 0; i < 4; i++) drive(8'hFF, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check("writes_line_144", 32'(wen_cnt - base), 0);

        // X and Y saturation
        for (int i = 0; i < 260; i++) begin
            drive(8'h11, 1'b1, 1'b0);
            drive(8'h22, 1'b1, 1'b0);
        end
        check("x_saturate", 32'(cam.X_ADDR), 255);
        drive(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 110; i++) begin
            drive(8'hFF, 1'b1, 1'b0);
            drive(8'h00, 1'b0, 1'b0);
        end
        check("y_saturate", 32'(cam.Y_ADDR), 255);

        // VSYNC rise mid-line with a partial pixel pending
        drive(8'hE0, 1'b1, 1'b0);
        drive(8'h18, 1'b1, 1'b0);
        drive(8'hFF, 1'b1, 1'b0);
        drive(8'hFF, 1'b1, 1'b1);
        check("frame_done_pulse", 32'(cam.FRAME_DONE), 1);
        drive(8'h00, 1'b1, 1'b1);
        check("frame_done_clear", 32'(cam.FRAME_DONE), 0);
        drive(8'h18, 1'b0, 1'b1);
        drive(8'hE0, 1'b1, 1'b1);
        drive(8'h18, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b1);

        // new frame; VSYNC rises right after a completed pixel
        drive(8'h00, 1'b0, 1'b0);
        check("x_frame_start", 32'(cam.X_ADDR), 0);
        check("y_frame_start", 32'(cam.Y_ADDR), 0);
        drive(8'hE0, 1'b1, 1'b0);
        push(0, 8'hE3);
        drive(8'h18, 1'b1, 1'b0);
        drive(8'hAA, 1'b1, 1'b1);
        check("frame_done_2", 32'(cam.FRAME_DONE), 1);
        drive(8'h00, 1'b0, 1'b1);

        // reset mid-line, then no writes until the next frame start
        drive(8'h00, 1'b0, 1'b0);
        drive(8'hE0, 1'b1, 1'b0);
        rst = 1'b1;
        drive(8'h18, 1'b1, 1'b0);
        rst = 1'b0;
        check_reset_outputs("reset_mid_line");
        for (int i = 0; i < 4; i++) begin
            drive(8'hE0, 1'b1, 1'b0);
            drive(8'h18, 1'b1, 1'b0);
        end
        drive(8'h00, 1'b0, 1'b0);
        check("x_after_reset_line", 32'(cam.X_ADDR), 0);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h07, 1'b1, 1'b0);
        push(0, 8'h1C);
        drive(8'hE0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);

        check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
